ddu_debug_ctrl: RTL and testbench
=================================

// Module: ddu_debug_ctrl
// PURPOSE
//  Next-generation debug display unit between the board I/O and the pipelined CPU.
//  Gates the CPU clock with three modes: halt, single step (exactly one full clk_out period) and free run.
//  Free run can stop on a PC breakpoint.
//  Debounces step/inc/dec, auto-repeats inc/dec while held, and browses mem/reg addresses.
//  Outputs the selected 32-bit word for an external 7-segment driver.
// PARAMETERS
//  DB_W    20  debounce counter width; press accepted at count 2^DB_W-2
//  RPT_W   22  auto-repeat counter width; one extra inc/dec pulse per 2^RPT_W cycles held
//  MEM_AW  8   memory word-address width (1..30)
//  REG_AW  5   register-address width (1..32)
// PORTS
//  clk_in     in   1   board clock; all logic on posedge
//  rst_n      in   1   synchronous reset, active-low
//  cont       in   1   run switch (level)
//  step       in   1   single-step button (raw)
//  mem        in   1   1 = browse memory, 0 = browse registers
//  inc, dec   in   1   address up/down buttons (raw)
//  bp_en      in   1   breakpoint enable
//  bp_addr    in   32  breakpoint PC
//  pc         in   32  CPU PC
//  mem_data   in   32  data at addr, memory space
//  reg_data   in   32  data at addr, register space
//  clk_out    out  1   gated CPU clock (registered)
//  addr       out  32  mem ? {0,mem_addr,2'b00} : {0,reg_addr}
//  led        out  16  [15:8]=pc[9:2]; [7:0]=low 8 bits of selected addr index, zero-extended
//  disp_data  out  32  mem ? mem_data : reg_data (combinational)
//  halted     out  1   FSM in HALT
//  bp_hit     out  1   halted by breakpoint
// BEHAVIOUR
//  Reset (rst_n=0 at posedge) values:
//  - clk_out=0, FSM=HALT, bp_hit=0
//  - mem_addr=0, reg_addr=0
//  - all debounce/repeat counters=0
//  Debounce, per button:
//  - DB_W counter clears while the raw input is 0.
//  - Counts up while the input is 1 and saturates at all-ones.
//  - One-cycle press pulse when count==2^DB_W-2, so one pulse per press.
//  Auto-repeat (inc/dec only):
//  - RPT_W counter runs while the debounce counter is saturated.
//  - One extra pulse each time it wraps to 0; clears on release.
//  - step never repeats.
//  Address update (combinational mux; update lands one cycle after the pulse):
//  - Only the space selected by mem changes; the other index is held.
//  - inc pulse: +1; dec pulse: -1; both in the same cycle: inc wins.
//  - Modulo 2^MEM_AW / 2^REG_AW (0-1 wraps to all-ones).
//  FSM (clk_out changes only on FSM transitions):
//  - HALT: clk_out held low.
//    - step pulse: S_HI (clk_out=1 next cycle), clears bp_hit.
//    - Else cont_rise, or cont=1 with bp_hit=0: RUN.
//  - S_HI -> S_LO (clk_out=0) -> HALT. Step = exactly 1 rising + 1 falling edge. Inputs ignored during S_HI/S_LO.
//  - RUN: each cycle clk_out toggles, except when clk_out==0 and any of:
//    - cont==0: HALT, clk_out stays 0.
//    - bp_en && pc==bp_addr: HALT, bp_hit=1, clk_out stays 0; instruction at bp_addr not yet clocked.
//  - cont_rise is registered edge detect of cont; bp_hit blocks restart while cont stays 1.
//  - cont=1 at reset release (no rise): first posedge with rst_n=1 enters RUN (bp_hit=0).
//  - Halting only with clk_out=0 guarantees no runt pulse.
//  - Reset mid-RUN/S_HI forces clk_out=0 next cycle.
//  - Mode switch (mem toggled) never alters either stored index.
// TESTING (bench params DB_W=4, RPT_W=5)
//  1. Reset with all inputs 0 -> clk_out=0, addr=0, led=0, halted=1, bp_hit=0.
//  2. step high 40 cycles -> one press pulse 14 cycles after first sampled high.
//     Then clk_out=1 one cycle, 0 the next. Exactly one period, no repeat.
//  3. mem=1, inc held 80 cycles:
//     - addr 0->4 at debounce, then +4 every 32 cycles.
//     - Reset, then dec press -> mem_addr=0xFF, addr=0x3FC; reg_addr unchanged.
//  4. cont=1, bp_en=1, bp_addr=0x0C, PC model +4 per clk_out posedge from 0:
//     - Halts with clk_out=0, pc=0x0C, bp_hit=1; stays halted while cont=1.
//     - cont 0->1 resumes; pc reaches 0x10.
//  5. rst_n=0 during RUN with clk_out=1 -> next cycle clk_out=0, halted=1, addrs 0.
//  6. inc and dec pulses in same cycle, reg_addr=5 -> reg_addr=6.
//     reg_addr=31 + inc -> 0.

Source files
------------

// File: rtl/ddu_debug_ctrl.sv
// ddu_debug_ctrl: debug display unit between the board I/O and a pipelined CPU.
//
// Gates the CPU clock in three modes:
//   halt        - clk_out held low.
//   single step - exactly one full clk_out period (one rise, one fall).
//   free run    - clk_out toggles every cycle, optionally stopping at a PC breakpoint.
// Debounces the step/inc/dec buttons. Holding inc or dec auto-repeats the pulse.
// inc/dec browse a memory word index or a register index. The word selected by
// the current index goes out for an external 7-segment driver.
//
// Handshake note: there is no valid/ready traffic in this block. Every button
// becomes a single-cycle pulse, and each consumer acts on the clock edge that
// samples that pulse.
//
// Ports (top):
//   clk_in     in   1   board clock, all logic on posedge
//   rst_n      in   1   synchronous reset, active-low
//   cont       in   1   run switch (level)
//   step       in   1   single-step button (raw)
//   mem        in   1   1 = browse memory, 0 = browse registers
//   inc, dec   in   1   address up/down buttons (raw)
//   bp_en      in   1   breakpoint enable
//   bp_addr    in   32  breakpoint PC
//   pc         in   32  CPU PC
//   mem_data   in   32  word at addr, memory space
//   reg_data   in   32  word at addr, register space
//   clk_out    out  1   gated CPU clock (registered)
//   addr       out  32  byte address of the selected memory word, or the register index
//   led        out  16  {pc[9:2], low 8 bits of the selected index}
//   disp_data  out  32  selected data word (combinational)
//   halted     out  1   controller is in HALT
//   bp_hit     out  1   halted by the breakpoint

// Button conditioner: debounce counter plus an optional auto-repeat counter.
//   clk, rst_n  clock and synchronous active-low reset
//   raw         raw button level
//   pulse       one-cycle press pulse, plus repeat pulses when RPT_EN is set
module ddu_debounce #(
  parameter int DB_W   = 20,
  parameter int RPT_W  = 22,
  parameter bit RPT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  // Fire one count below saturation. The counter passes this value exactly
  // once per press, so each press gives exactly one pulse.
  localparam logic [DB_W-1:0] DB_FIRE = {{(DB_W-1){1'b1}}, 1'b0};

  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             sat;

  assign sat = &db_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      rpt_cnt <= '0;
    end else begin
      if (!raw) begin
        db_cnt <= '0;
      end else if (!sat) begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (!raw || !sat) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

  // The repeat pulse marks the cycle just before rpt_cnt wraps to 0.
  assign pulse = (db_cnt == DB_FIRE) || (RPT_EN && sat && (&rpt_cnt));
endmodule

module ddu_debug_ctrl #(
  parameter int DB_W   = 20,
  parameter int RPT_W  = 22,
  parameter int MEM_AW = 8,
  parameter int REG_AW = 5
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        cont,
  input  logic        step,
  input  logic        mem,
  input  logic        inc,
  input  logic        dec,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  output logic        clk_out,
  output logic [31:0] addr,
  output logic [15:0] led,
  output logic [31:0] disp_data,
  output logic        halted,
  output logic        bp_hit
);
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_S_HI = 2'd1,
    ST_S_LO = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                clk_out_d, bp_hit_d;
  logic                cont_q, cont_rise, bp_match;
  logic                step_p, inc_p, dec_p;
  logic [MEM_AW-1:0]   mem_addr;
  logic [REG_AW-1:0]   reg_addr;

  ddu_debounce #(.DB_W(DB_W), .RPT_W(RPT_W), .RPT_EN(1'b0)) u_db_step (
    .clk(clk_in), .rst_n(rst_n), .raw(step), .pulse(step_p)
  );
  ddu_debounce #(.DB_W(DB_W), .RPT_W(RPT_W), .RPT_EN(1'b1)) u_db_inc (
    .clk(clk_in), .rst_n(rst_n), .raw(inc), .pulse(inc_p)
  );
  ddu_debounce #(.DB_W(DB_W), .RPT_W(RPT_W), .RPT_EN(1'b1)) u_db_dec (
    .clk(clk_in), .rst_n(rst_n), .raw(dec), .pulse(dec_p)
  );

  assign cont_rise = cont && !cont_q;
  assign bp_match  = bp_en && (pc == bp_addr);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      clk_out <= 1'b0;
      bp_hit  <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_out <= clk_out_d;
      bp_hit  <= bp_hit_d;
      cont_q  <= cont;
    end
  end

  // Leaving HALT always starts a rising edge of clk_out. So when a run resumes
  // from a breakpoint, the instruction at bp_addr is clocked before the
  // breakpoint compare runs again.
  // RUN checks for a stop only while clk_out is low. A halt therefore never
  // cuts a high phase short.
  always_comb begin
    state_d   = state_q;
    clk_out_d = clk_out;
    bp_hit_d  = bp_hit;
    unique case (state_q)
      ST_HALT: begin
        clk_out_d = 1'b0;
        if (step_p) begin
          state_d   = ST_S_HI;
          clk_out_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (cont_rise || (cont && !bp_hit)) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          bp_hit_d  = 1'b0;
        end
      end
      ST_S_HI: begin
        state_d   = ST_S_LO;
        clk_out_d = 1'b0;
      end
      ST_S_LO: begin
        state_d   = ST_HALT;
        clk_out_d = 1'b0;
      end
      ST_RUN: begin
        if (clk_out) begin
          clk_out_d = 1'b0;
        end else if (!cont) begin
          state_d = ST_HALT;
        end else if (bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          clk_out_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_HALT;
        clk_out_d = 1'b0;
      end
    endcase
  end

  // Only the space selected by mem moves. If inc and dec pulse together, inc wins.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      mem_addr <= '0;
      reg_addr <= '0;
    end else if (inc_p) begin
      if (mem) mem_addr <= mem_addr + MEM_AW'(1);
      else     reg_addr <= reg_addr + REG_AW'(1);
    end else if (dec_p) begin
      if (mem) mem_addr <= mem_addr - MEM_AW'(1);
      else     reg_addr <= reg_addr - REG_AW'(1);
    end
  end

  assign addr      = mem ? 32'({mem_addr, 2'b00}) : 32'(reg_addr);
  assign led       = {pc[9:2], 8'(mem ? 32'(mem_addr) : 32'(reg_addr))};
  assign disp_data = mem ? mem_data : reg_data;
  assign halted    = (state_q == ST_HALT);
endmodule

// File: tb/tb_ddu_debug_ctrl.sv
// Testbench for ddu_debug_ctrl with DB_W=4, RPT_W=5.
// A reference model counts how many consecutive cycles each button has been
// held. From that it predicts the address index: the first pulse comes at hold
// count 14, and one more every 32 cycles after that. Clock-gating behaviour is
// checked with directed steps whose expected timing is written out directly.
// The bench plays the CPU: pc advances by 4 on every rising edge of clk_out.
module tb_ddu_debug_ctrl;
  localparam int DB_W   = 4;
  localparam int RPT_W  = 5;
  localparam int MEM_AW = 8;
  localparam int REG_AW = 5;
  localparam int FIRE   = (1 << DB_W) - 2;
  localparam int RPT    = 1 << RPT_W;
  localparam int MEM_SZ = 1 << MEM_AW;
  localparam int REG_SZ = 1 << REG_AW;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0, cont = 1'b0, step = 1'b0, mem = 1'b0;
  logic        inc = 1'b0, dec = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc = '0, mem_data = '0, reg_data = '0;
  logic        clk_out, halted, bp_hit;
  logic [31:0] addr, disp_data;
  logic [15:0] led;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int hold_inc = 0, hold_dec = 0, m_mem = 0, m_reg = 0;
  logic clk_prev = 1'b0;

  ddu_debug_ctrl #(.DB_W(DB_W), .RPT_W(RPT_W), .MEM_AW(MEM_AW), .REG_AW(REG_AW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cont(cont), .step(step), .mem(mem),
    .inc(inc), .dec(dec), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .mem_data(mem_data), .reg_data(reg_data), .clk_out(clk_out), .addr(addr),
    .led(led), .disp_data(disp_data), .halted(halted), .bp_hit(bp_hit)
  );

  // clock/reset block
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit fires(input int hold);
    return (hold >= FIRE) && (((hold - FIRE) % RPT) == 0);
  endfunction

  // Advance the model across the coming posedge, then step the clock.
  task automatic cyc();
    if (!rst_n) begin
      m_mem = 0; m_reg = 0; hold_inc = 0; hold_dec = 0;
    end else begin
      if (fires(hold_inc)) begin
        if (mem) m_mem = (m_mem + 1) % MEM_SZ;
        else     m_reg = (m_reg + 1) % REG_SZ;
      end else if (fires(hold_dec)) begin
        if (mem) m_mem = (m_mem + MEM_SZ - 1) % MEM_SZ;
        else     m_reg = (m_reg + REG_SZ - 1) % REG_SZ;
      end
      hold_inc = inc ? hold_inc + 1 : 0;
      hold_dec = dec ? hold_dec + 1 : 0;
    end
    @(posedge clk_in);
    #1;
    if (clk_out && !clk_prev) pc = pc + 32'd4;
    clk_prev = clk_out;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic check_view();
    logic [31:0] e_addr, e_idx, e_led;
    e_idx  = mem ? 32'(m_mem) : 32'(m_reg);
    e_addr = mem ? 32'(m_mem * 4) : 32'(m_reg);
    e_led  = {16'd0, pc[9:2], e_idx[7:0]};
    chk("addr", addr, e_addr);
    chk("led", 32'(led), e_led);
    chk("disp_data", disp_data, mem ? mem_data : reg_data);
  endtask

  // driver: hold a button pattern for n cycles, then release for 3 cycles
  task automatic press(input logic i, input logic d, input int n);
    inc = i; dec = d;
    repeat (n) begin cyc(); check_view(); end
    inc = 1'b0; dec = 1'b0;
    repeat (3) begin cyc(); check_view(); end
  endtask

  initial begin
    // 1. reset state
    cyc(); cyc();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 2. single step: pulse after 14 sampled highs, S_HI on the 15th edge
    step = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk("step_clk_out", 32'(clk_out), 32'(i == 15));
      chk("step_halted", 32'(halted), 32'(!(i == 15 || i == 16)));
    end
    step = 1'b0;
    cyc();

    // 3. memory browse with auto-repeat
    mem = 1'b1;
    mem_data = 32'hA5A5_0001;
    inc = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      check_view();
      if (i == 14) chk("rpt_before", addr, 32'h0);
      if (i == 15) chk("rpt_first", addr, 32'h4);
      if (i == 46) chk("rpt_hold", addr, 32'h4);
      if (i == 47) chk("rpt_second", addr, 32'h8);
    end
    chk("rpt_final", addr, 32'hC);
    inc = 1'b0;
    cyc();
    do_reset();
    press(1'b0, 1'b1, 16);
    chk("dec_wrap_addr", addr, 32'h3FC);
    chk("dec_wrap_led", 32'(led[7:0]), 32'hFF);
    mem = 1'b0;
    #1;
    chk("dec_reg_held", addr, 32'h0);

    // 4. breakpoint run
    pc = '0; bp_addr = 32'h0C; bp_en = 1'b1; cont = 1'b1;
    for (int k = 0; k < 60 && !(halted && bp_hit); k++) cyc();
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_clk_out", 32'(clk_out), 32'd0);
    chk("bp_pc", pc, 32'h0C);
    repeat (10) begin
      cyc();
      chk("bp_stay", 32'(halted), 32'd1);
    end
    cont = 1'b0;
    cyc();
    chk("bp_cont_low", 32'(halted), 32'd1);
    cont = 1'b1;
    for (int k = 0; k < 20 && pc != 32'h10; k++) cyc();
    chk("bp_resume_pc", pc, 32'h10);
    chk("bp_resume_hit", 32'(bp_hit), 32'd0);
    cont = 1'b0; bp_en = 1'b0;
    for (int k = 0; k < 10 && !halted; k++) cyc();
    chk("stop_halted", 32'(halted), 32'd1);
    chk("stop_clk_out", 32'(clk_out), 32'd0);

    // 5. reset while running with clk_out high
    mem = 1'b1;
    cont = 1'b1;
    for (int k = 0; k < 10 && !(clk_out && !halted); k++) cyc();
    chk("run_clk_high", 32'(clk_out), 32'd1);
    chk("run_addr_pre", addr, 32'h3FC);
    do_reset();
    cont = 1'b0;
    chk("mid_rst_clk_out", 32'(clk_out), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd1);
    chk("mid_rst_mem_addr", addr, 32'h0);
    mem = 1'b0;
    #1;
    chk("mid_rst_reg_addr", addr, 32'h0);

    // 6. register browse: inc priority and wrap
    repeat (5) press(1'b1, 1'b0, 16);
    chk("reg_five", addr, 32'd5);
    press(1'b1, 1'b1, 16);
    chk("reg_both_inc_wins", addr, 32'd6);
    repeat (7) press(1'b0, 1'b1, 16);
    chk("reg_wrap_down", addr, 32'd31);
    press(1'b1, 1'b0, 16);
    chk("reg_wrap_up", addr, 32'd0);

    // randomized browsing against the model
    for (int n = 0; n < 30; n++) begin
      int pat;
      mem      = 1'($urandom_range(0, 1));
      mem_data = $urandom;
      reg_data = $urandom;
      pc       = $urandom;
      pat      = $urandom_range(0, 3);
      press(1'(pat & 1), 1'(pat >> 1), $urandom_range(1, 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
